axi_regfile_v2: RTL and testbench

//  Parametrised AXI4-Lite register file, the next generation of the fixed 8-register axi_regfile.
//  - Provides C_NUM_REGS control registers out to fabric and C_NUM_REGS status inputs back to the host.
//  - Adds: per-register read-only/read-write mode, per-register write/read strobes, WSTRB byte enables,
//    and SLVERR on illegal access.
//  - Sits between the AXI-Lite interconnect (PCIe BAR / host) and user logic.

---
 rtl/axi_regfile_pkg.sv | 23 ++
 rtl/axi_regfile_wr_ch.sv | 105 ++++++++++
 rtl/axi_regfile_v2.sv | 153 +++++++++++++++
 tb/tb_axi_regfile_v2.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_regfile_pkg.sv
// Shared constants, write-FSM state type and register-mode helper for the
// parametrised AXI4-Lite register file.
package axi_regfile_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Widest read-only mask the helper understands; C_NUM_REGS must not exceed it.
    localparam int MAX_REGS  = 64;
    localparam int MAX_IDX_W = 6;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_COMMIT,
        WR_RESP
    } wr_state_e;

    function automatic logic reg_is_ro(input logic [MAX_REGS-1:0] mask,
                                       input logic [31:0]         idx);
        return (idx < MAX_REGS) ? mask[idx[MAX_IDX_W-1:0]] : 1'b0;
    endfunction

endpackage

// File: rtl/axi_regfile_wr_ch.sv
// AXI4-Lite write channel: independent AW/W capture buffers, a one-cycle
// commit and the B handshake. Emits a single-cycle write request to the array.
module axi_regfile_wr_ch
    import axi_regfile_pkg::*;
#(
    parameter int                  ADDR_IDX_W = 4,
    parameter int                  NUM_REGS   = 16,
    parameter logic [MAX_REGS-1:0] RO_MASK    = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_IDX_W-1:0] awidx_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [1:0]            bresp_o,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic                  wr_en_o,
    output logic [ADDR_IDX_W-1:0] wr_idx_o,
    output logic [31:0]           wr_data_o,
    output logic [3:0]            wr_strb_o
);

    wr_state_e             state_q;
    logic                  awready_q, wready_q;
    logic                  aw_full_q, w_full_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic [ADDR_IDX_W-1:0] aw_idx_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;

    logic aw_hs, w_hs, aw_full_d, w_full_d, access_err;

    assign aw_hs     = awready_q & awvalid_i;
    assign w_hs      = wready_q & wvalid_i;
    assign aw_full_d = aw_full_q | aw_hs;
    assign w_full_d  = w_full_q | w_hs;

    // Out-of-range and read-only targets are refused without touching the array.
    assign access_err = (32'(aw_idx_q) >= NUM_REGS) || reg_is_ro(RO_MASK, 32'(aw_idx_q));

    // NOTE: every register here is written with <= so all of them update
    // together from the values that held before the edge; = would make later
    // lines in the block see already-updated state and break the FSM timing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= WR_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            case (state_q)
                WR_IDLE: begin
                    if (aw_hs) aw_idx_q <= awidx_i;
                    if (w_hs) begin
                        wdata_q <= wdata_i;
                        wstrb_q <= wstrb_i;
                    end
                    aw_full_q <= aw_full_d;
                    w_full_q  <= w_full_d;
                    awready_q <= ~aw_full_d;
                    wready_q  <= ~w_full_d;
                    if (aw_full_d && w_full_d) state_q <= WR_COMMIT;
                end
                WR_COMMIT: begin
                    aw_full_q <= 1'b0;
                    w_full_q  <= 1'b0;
                    bvalid_q  <= 1'b1;
                    bresp_q   <= access_err ? RESP_SLVERR : RESP_OKAY;
                    state_q   <= WR_RESP;
                end
                WR_RESP: begin
                    if (bready_i) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        state_q   <= WR_IDLE;
                    end
                end
                default: state_q <= WR_IDLE;
            endcase
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign wr_en_o   = (state_q == WR_COMMIT) && !access_err;
    assign wr_idx_o  = aw_idx_q;
    assign wr_data_o = wdata_q;
    assign wr_strb_o = wstrb_q;

endmodule

// File: rtl/axi_regfile_v2.sv
// Parametrised AXI4-Lite register file: C_NUM_REGS control words out to fabric,
// read-only status words back to the host, byte enables and per-register strobes.
module axi_regfile_v2
    import axi_regfile_pkg::*;
#(
    parameter int                       C_S_AXI_DATA_WIDTH = 32,
    parameter int                       C_S_AXI_ADDR_WIDTH = 6,
    parameter int                       C_NUM_REGS         = 16,
    parameter logic [C_NUM_REGS-1:0]    C_RO_MASK          = '0,
    parameter logic [C_NUM_REGS*32-1:0] C_RST_VAL          = '0
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_NUM_REGS*32-1:0]        reg_out,
    input  logic [C_NUM_REGS*32-1:0]        reg_in,
    output logic [C_NUM_REGS-1:0]           reg_wr_stb,
    output logic [C_NUM_REGS-1:0]           reg_rd_stb
);

    localparam int                  IDX_W       = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [MAX_REGS-1:0] RO_MASK_EXT = MAX_REGS'(C_RO_MASK);

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_data;
    logic [3:0]       wr_strb;

    axi_regfile_wr_ch #(
        .ADDR_IDX_W (IDX_W),
        .NUM_REGS   (C_NUM_REGS),
        .RO_MASK    (RO_MASK_EXT)
    ) u_wr_ch (
        .clk_i     (S_AXI_ACLK),
        .rst_i     (S_AXI_ARESET),
        .awidx_i   (S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]),
        .awvalid_i (S_AXI_AWVALID),
        .awready_o (S_AXI_AWREADY),
        .wdata_i   (S_AXI_WDATA),
        .wstrb_i   (S_AXI_WSTRB),
        .wvalid_i  (S_AXI_WVALID),
        .wready_o  (S_AXI_WREADY),
        .bresp_o   (S_AXI_BRESP),
        .bvalid_o  (S_AXI_BVALID),
        .bready_i  (S_AXI_BREADY),
        .wr_en_o   (wr_en),
        .wr_idx_o  (wr_idx),
        .wr_data_o (wr_data),
        .wr_strb_o (wr_strb)
    );

    logic [C_NUM_REGS*32-1:0] reg_q;
    logic [C_NUM_REGS-1:0]    wr_stb_q;
    logic [C_NUM_REGS-1:0]    wr_sel;

    // NOTE: every signal assigned in an always_comb gets a default on the first
    // line; a path that leaves it unassigned would otherwise infer a latch.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            wr_sel[i] = wr_en && (wr_idx == IDX_W'(i));
        end
    end

    // NOTE: these are individual control flops that fabric relies on from the
    // first cycle, so they take C_RST_VAL; a RAM-style array would not be reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            reg_q    <= C_RST_VAL;
            wr_stb_q <= '0;
        end else begin
            wr_stb_q <= wr_sel;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_sel[i] && wr_strb[b]) reg_q[32*i+8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    logic [IDX_W-1:0]              ar_idx;
    logic                          ar_hs, ar_in_range;
    logic [31:0]                   rd_word;
    logic                          arready_q, rvalid_q;
    logic [1:0]                    rresp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

    assign ar_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_hs       = arready_q & S_AXI_ARVALID;
    assign ar_in_range = 32'(ar_idx) < C_NUM_REGS;

    // Out-of-range indices match no entry and fall through to zero.
    always_comb begin
        rd_word    = '0;
        reg_rd_stb = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rd_word       = reg_is_ro(RO_MASK_EXT, i) ? reg_in[32*i +: 32] : reg_q[32*i +: 32];
                reg_rd_stb[i] = ar_hs;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else if (ar_hs) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_word;
            rresp_q   <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q) begin
            if (S_AXI_RREADY) begin
                rvalid_q  <= 1'b0;
                arready_q <= 1'b1;
            end
        end else begin
            arready_q <= 1'b1;
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign reg_out       = reg_q;
    assign reg_wr_stb    = wr_stb_q;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], reg_in};

endmodule

// File: tb/tb_axi_regfile_v2.sv
// Randomised self-checking bench for axi_regfile_v2 against a transaction-level
// model of the register file (array of words, read-only mask, reset image).
module tb_axi_regfile_v2;

    localparam int             AW = 7;
    localparam int             NR = 16;
    localparam logic [NR-1:0]  RO = 16'h0220;
    localparam logic [1:0]     OKAY = 2'b00;
    localparam logic [1:0]     SLVERR = 2'b10;

    function automatic logic [31:0] rst_word(input int i);
        return (i % 4 == 2) ? 32'h0 : 32'hC0DE_0000 + 32'(i) * 32'h0000_1111;
    endfunction

    function automatic logic [NR*32-1:0] mk_rst();
        logic [NR*32-1:0] v;
        for (int i = 0; i < NR; i++) v[32*i +: 32] = rst_word(i);
        return v;
    endfunction

    localparam logic [NR*32-1:0] RST = mk_rst();

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   awaddr, araddr;
    logic [2:0]      awprot, arprot;
    logic            awvalid, awready, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rvalid, rready;
    logic [31:0]     wdata, rdata;
    logic [3:0]      wstrb;
    logic [1:0]      bresp, rresp;
    logic [NR*32-1:0] reg_out, reg_in;
    logic [NR-1:0]   reg_wr_stb, reg_rd_stb;

    always #5 clk = ~clk;

    axi_regfile_v2 #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (AW),
        .C_NUM_REGS         (NR),
        .C_RO_MASK          (RO),
        .C_RST_VAL          (RST)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_out       (reg_out),
        .reg_in        (reg_in),
        .reg_wr_stb    (reg_wr_stb),
        .reg_rd_stb    (reg_rd_stb)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_out [NR];
    int          wr_cnt [NR];
    int          rd_cnt [NR];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            wr_cnt[i] += int'(reg_wr_stb[i]);
            rd_cnt[i] += int'(reg_rd_stb[i]);
        end
    end

    function automatic int sum_cnt(input bit wr);
        int s = 0;
        for (int i = 0; i < NR; i++) s += wr ? wr_cnt[i] : rd_cnt[i];
        return s;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        for (int i = 0; i < NR; i++) m_out[i] = rst_word(i);
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < NR; i++)
            check($sformatf("%s reg_out[%0d]", tag, i), reg_out[32*i +: 32], m_out[i]);
    endtask

    task automatic send_aw(input logic [AW-1:0] a, input int dly);
        repeat (dly) cyc();
        awaddr  = a;
        awvalid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (awready) begin
                cyc();
                awvalid = 1'b0;
                return;
            end
        end
        check("aw_timeout", 32'd0, 32'd1);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        repeat (dly) cyc();
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (wready) begin
                cyc();
                wvalid = 1'b0;
                return;
            end
        end
        check("w_timeout", 32'd0, 32'd1);
        wvalid = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp, output bit ok);
        ok = 1'b0;
        resp = 2'bxx;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bvalid) begin
                resp = bresp;
                ok = 1'b1;
                return;
            end
        end
        check("b_timeout", 32'd0, 32'd1);
    endtask

    // Called at a negedge where BVALID is high; stalls BREADY then completes B.
    task automatic b_finish(input int stall);
        logic [1:0] r;
        r = bresp;
        repeat (stall) begin
            @(negedge clk);
            check("b_hold_valid", 32'(bvalid), 32'd1);
            check("b_hold_resp", 32'(bresp), 32'(r));
            check("aw_w_ready_while_b", 32'({awready, wready}), 32'd0);
        end
        bready = 1'b1;
        cyc();
        bready = 1'b0;
    endtask

    task automatic write_txn(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int stall);
        int         idx, tot0, idx0;
        bit         exp_ok, ok;
        logic [1:0] r;
        idx    = int'(a) >> 2;
        exp_ok = (idx < NR) ? !RO[idx] : 1'b0;
        tot0   = sum_cnt(1'b1);
        idx0   = (idx < NR) ? wr_cnt[idx] : 0;
        fork
            send_aw(a, aw_dly);
            send_w(d, s, w_dly);
        join
        wait_b(r, ok);
        if (!ok) return;
        check($sformatf("bresp idx%0d", idx), 32'(r), exp_ok ? 32'(OKAY) : 32'(SLVERR));
        b_finish(stall);
        if (exp_ok) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_out[idx][8*b +: 8] = d[8*b +: 8];
            check($sformatf("wr_stb idx%0d", idx), 32'(wr_cnt[idx] - idx0), 32'd1);
        end
        check("wr_stb_total", 32'(sum_cnt(1'b1) - tot0), exp_ok ? 32'd1 : 32'd0);
        check_all_regs("wr");
    endtask

    task automatic read_txn(input logic [AW-1:0] a, input int ar_dly, input int stall, input bit scramble);
        int          idx, tot0;
        bit          found;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        idx   = int'(a) >> 2;
        tot0  = sum_cnt(1'b0);
        found = 1'b0;
        repeat (ar_dly) cyc();
        araddr  = a;
        arvalid = 1'b1;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (arready) found = 1'b1;
        end
        if (!found) begin
            check("ar_timeout", 32'd0, 32'd1);
            arvalid = 1'b0;
            return;
        end
        if (idx < NR) begin
            exp_d = RO[idx] ? reg_in[32*idx +: 32] : m_out[idx];
            exp_r = OKAY;
        end else begin
            exp_d = 32'h0;
            exp_r = SLVERR;
        end
        cyc();
        arvalid = 1'b0;
        if (scramble)
            for (int i = 0; i < NR; i++) reg_in[32*i +: 32] = $urandom;
        @(negedge clk);
        check("rvalid_latency", 32'(rvalid), 32'd1);
        check($sformatf("rdata idx%0d", idx), rdata, exp_d);
        check($sformatf("rresp idx%0d", idx), 32'(rresp), 32'(exp_r));
        repeat (stall) begin
            @(negedge clk);
            check("r_hold_valid", 32'(rvalid), 32'd1);
            check("r_hold_data", rdata, exp_d);
            check("r_hold_resp", 32'(rresp), 32'(exp_r));
            check("arready_while_r", 32'(arready), 32'd0);
        end
        rready = 1'b1;
        cyc();
        rready = 1'b0;
        check("rd_stb_total", 32'(sum_cnt(1'b0) - tot0), (idx < NR) ? 32'd1 : 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cyc();
        @(negedge clk);
        check("rst_ready", 32'({awready, wready, arready}), 32'd0);
        check("rst_valid", 32'({bvalid, rvalid}), 32'd0);
        check("rst_resp", 32'({bresp, rresp}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_stb", 32'({reg_wr_stb, reg_rd_stb}), 32'd0);
        reset_model();
        check_all_regs("rst");
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r;
        bit          ok;
        logic [31:0] old3, new3;
        int          idx;
        logic [AW-1:0] a;

        rst = 1'b1;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = '0; wstrb = '0;
        for (int i = 0; i < NR; i++) begin
            reg_in[32*i +: 32] = $urandom;
            wr_cnt[i] = 0;
            rd_cnt[i] = 0;
        end
        do_reset(3);

        // Every register reads back its reset image (or its status input if read-only).
        for (int i = 0; i < NR; i++) read_txn(AW'(i << 2), 0, 0, 1'b0);

        // AW first, W three cycles later, sparse byte enables on a zero-reset register.
        write_txn(AW'(2 << 2), 32'hDEAD_BEEF, 4'b0101, 0, 3, 0);
        check("t2_reg2", reg_out[32*2 +: 32], 32'h00AD_00EF);
        // W ahead of AW, then a zero-strobe write that must leave data alone.
        write_txn(AW'(7 << 2), 32'h1357_9BDF, 4'b1111, 2, 0, 1);
        write_txn(AW'(7 << 2), 32'hFFFF_FFFF, 4'b0000, 0, 0, 0);

        // Read-only register: write refused, read returns the status input.
        write_txn(AW'(5 << 2), 32'hAAAA_5555, 4'b1111, 0, 0, 0);
        reg_in[32*5 +: 32] = 32'h1234_5678;
        read_txn(AW'(5 << 2), 0, 0, 1'b0);
        check("t3_rd_stb5", 32'(rd_cnt[5] > 0), 32'd1);

        // First index past the array and the top of the address space.
        read_txn(AW'(NR << 2), 0, 0, 1'b0);
        write_txn(AW'(NR << 2), 32'h0BAD_F00D, 4'b1111, 0, 0, 0);
        read_txn(AW'(7'h7F), 1, 0, 1'b0);

        // Long back-pressure on both response channels.
        write_txn(AW'(4 << 2), 32'hCAFE_F00D, 4'b1111, 0, 0, 10);
        read_txn(AW'(4 << 2), 0, 10, 1'b0);

        // Read handshake lands in the commit cycle: returns the pre-write value.
        old3 = m_out[3];
        new3 = ~old3;
        awaddr = AW'(3 << 2); awvalid = 1'b1;
        wdata = new3; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        check("sim_aw_w_ready", 32'({awready, wready}), 32'd3);
        cyc();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = AW'(3 << 2); arvalid = 1'b1;
        @(negedge clk);
        check("sim_arready", 32'(arready), 32'd1);
        cyc();
        arvalid = 1'b0;
        @(negedge clk);
        check("sim_rvalid", 32'(rvalid), 32'd1);
        check("sim_rdata_prewrite", rdata, old3);
        check("sim_bvalid", 32'(bvalid), 32'd1);
        bready = 1'b1; rready = 1'b1;
        cyc();
        bready = 1'b0; rready = 1'b0;
        m_out[3] = new3;
        check("sim_reg3_after", reg_out[32*3 +: 32], new3);

        // Reset while a response is pending drops it and restores the reset image.
        write_txn(AW'(1 << 2), 32'h7777_8888, 4'b1111, 0, 0, 0);
        fork
            send_aw(AW'(6 << 2), 0);
            send_w(32'h4242_4242, 4'hF, 0);
        join
        wait_b(r, ok);
        rst = 1'b1;
        @(negedge clk);
        check("t6_bvalid_cleared", 32'(bvalid), 32'd0);
        check("t6_reg1_rst", reg_out[32*1 +: 32], rst_word(1));
        check("t6_reg6_rst", reg_out[32*6 +: 32], rst_word(6));
        reset_model();
        rst = 1'b0;
        cyc();
        repeat (3) begin
            @(negedge clk);
            check("t6_no_b_after_rst", 32'(bvalid), 32'd0);
        end
        cyc();

        // A half-captured write (AW only) is forgotten across reset.
        send_aw(AW'(1 << 2), 0);
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        send_w(32'h600D_CAFE, 4'hF, 0);
        repeat (5) begin
            @(negedge clk);
            check("drop_no_b", 32'(bvalid), 32'd0);
        end
        cyc();
        send_aw(AW'(1 << 2), 0);
        wait_b(r, ok);
        if (ok) begin
            check("drop_bresp", 32'(r), 32'(OKAY));
            b_finish(0);
            m_out[1] = 32'h600D_CAFE;
        end
        check_all_regs("drop");

        // Randomised mix of reads and writes over in-range and out-of-range indices.
        for (int n = 0; n < 120; n++) begin
            idx = $urandom_range(0, 19);
            a   = AW'((idx << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                write_txn(a, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                read_txn(a, $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
